reg3_serial_tx: RTL and testbench
=================================

// Module: reg3_serial_tx
// PURPOSE
//  Parallel-to-serial reader for a 3-bit DFFRSE register word (same ed/sq convention).
//  Captures the word on a load request, then shifts it out on one line as a framed bit stream:
//  start bit, data bits LSB first, optional parity bit, stop bit.
//  Sits after the register bank; feeds the serial link to the display/debug board.
// PARAMETERS
//  WIDTH      3  data bits per frame (>=1)
//  PARITY_EN  1  1: insert parity bit after the data bits; 0: no parity bit
//  ODD_PAR    0  0: even parity; 1: odd parity (ignored when PARITY_EN=0)
// PORTS
//  eck    in   1      clock, rising edge
//  er     in   1      reset, asynchronous, active-low (er=0 resets)
//  eena   in   1      clock enable; 0 freezes all state and outputs
//  ed     in   WIDTH  parallel word to send
//  eld    in   1      load request, sampled only in IDLE
//  ecl    in   1      synchronous cancel, aborts current frame
//  sq     out  1      serial line; idle level 1
//  sbusy  out  1      1 while a frame is in progress (START..STOP)
//  sack   out  1      1-cycle pulse, word captured
//  sdone  out  1      1-cycle pulse, frame completed normally
// BEHAVIOUR
//  Reset (er=0, any time): state=IDLE, shift reg=0, bit count=0, sq=1, sbusy=0, sack=0, sdone=0.
//  All outputs registered. All updates on the rising edge of eck with eena=1 only.
//  eena=0: state, counter, shift reg, sq, sbusy held. sack/sdone also held (not cleared).
//  FSM states: IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE.
//  - IDLE: sq=1, sbusy=0. Edge with eld=1: shift reg<=ed, parity<=^ed ^ ODD_PAR, sack<=1, go to START.
//  - START: sq=0 for 1 cycle.
//  - DATA: WIDTH cycles, sq=shift[0], shift right each cycle. Count from 0 to WIDTH-1.
//  - PAR: only if PARITY_EN. sq=parity for 1 cycle.
//  - STOP: sq=1 for 1 cycle, sdone=1 in that cycle, then IDLE.
//  sack/sdone: high exactly one enabled cycle, then 0.
//  Frame length = 2+WIDTH+PARITY_EN enabled cycles. At least 1 IDLE cycle between frames.
//  Latency: sq goes low 1 enabled edge after the edge that samples eld.
//  Ignored inputs:
//  - eld outside IDLE: no sack, no effect.
//  - ed changing after capture: no effect on the frame in flight.
//  ecl=1 (enabled edge, any non-IDLE state): next state IDLE, sq=1, sbusy=0, no sdone.
//  ecl in IDLE: the load is not taken (ecl wins over eld), no sack.
//  ecl and eena=0 together: no effect.
//  eld held high: a new frame starts after each mandatory IDLE cycle.
//  Reset mid-frame: immediate return to the reset values; the partial frame is lost.
// TESTING
//  1. Reset with er=0, then release -> sq=1, sbusy=0, sack=0, sdone=0 until eld.
//  2. ed=3'b101, eld for 1 cycle, PARITY_EN=1, ODD_PAR=0
//     -> sack pulse; sq=0,1,0,1,0,1 on 6 successive cycles; sdone in the last cycle.
//  3. ed=3'b100, ODD_PAR=0 -> sq=0,0,0,1,1,1; same ed with ODD_PAR=1 -> parity bit 0.
//  4. Drop eena for 3 cycles in the middle of DATA -> sq/state frozen, then the sequence resumes
//     unchanged; total frame = 6+3 cycles.
//  5. ecl during the 2nd DATA bit -> sq=1, sbusy=0 next cycle, no sdone.
//     eld during the frame -> no sack.
//  6. er=0 during PAR -> sq=1, sbusy=0 immediately (asynchronously).
//     Next eld after release sends a fresh full frame.

Source files
------------

// File: rtl/reg3_serial_tx.sv
// Frames a captured WIDTH-bit word onto sq: start, data LSB first, optional parity, stop.
// sq leads with the start bit one enabled edge after the sack edge; eena=0 freezes every register.
module reg3_serial_tx #(
  parameter int WIDTH     = 3,
  parameter bit PARITY_EN = 1'b1,
  parameter bit ODD_PAR   = 1'b0
) (
  input  logic             eck,
  input  logic             er,
  input  logic             eena,
  input  logic [WIDTH-1:0] ed,
  input  logic             eld,
  input  logic             ecl,
  output logic             sq,
  output logic             sbusy,
  output logic             sack,
  output logic             sdone
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             par, par_n;
  logic             sq_n, sbusy_n, sack_n, sdone_n;

  always_ff @(posedge eck or negedge er) begin
    if (!er) begin
      state <= IDLE;
      shift <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      sq    <= 1'b1;
      sbusy <= 1'b0;
      sack  <= 1'b0;
      sdone <= 1'b0;
    end else if (eena) begin
      state <= state_n;
      shift <= shift_n;
      cnt   <= cnt_n;
      par   <= par_n;
      sq    <= sq_n;
      sbusy <= sbusy_n;
      sack  <= sack_n;
      sdone <= sdone_n;
    end
  end

  // Output registers are loaded from the current state, so sq trails the FSM by one edge.
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    par_n   = par;
    sq_n    = 1'b1;
    sbusy_n = 1'b1;
    sack_n  = 1'b0;
    sdone_n = 1'b0;
    case (state)
      IDLE: begin
        sbusy_n = 1'b0;
        if (eld && !ecl) begin
          shift_n = ed;
          par_n   = (^ed) ^ ODD_PAR;
          sack_n  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        sq_n    = 1'b0;
        cnt_n   = '0;
        state_n = DATA;
      end
      DATA: begin
        sq_n    = shift[0];
        shift_n = shift >> 1;
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = PARITY_EN ? PAR : STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PAR: begin
        sq_n    = par;
        state_n = STOP;
      end
      STOP: begin
        sdone_n = 1'b1;
        state_n = IDLE;
      end
      default: begin
        sbusy_n = 1'b0;
        state_n = IDLE;
      end
    endcase
    // Cancel drops the frame in flight; the stop pulse is suppressed too.
    if (ecl && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
      sq_n    = 1'b1;
      sbusy_n = 1'b0;
      sdone_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_reg3_serial_tx.sv
module tb_reg3_serial_tx;
  logic       eck;
  logic       er;
  logic       eena;
  logic [2:0] ed;
  logic       eld;
  logic       ecl;
  logic       sq, sbusy, sack, sdone;
  logic       sq_o, sbusy_o, sack_o, sdone_o;

  int checks = 0;
  int errors = 0;

  reg3_serial_tx #(.WIDTH(3), .PARITY_EN(1'b1), .ODD_PAR(1'b0)) u_even (
    .eck(eck), .er(er), .eena(eena), .ed(ed), .eld(eld), .ecl(ecl),
    .sq(sq), .sbusy(sbusy), .sack(sack), .sdone(sdone)
  );

  reg3_serial_tx #(.WIDTH(3), .PARITY_EN(1'b1), .ODD_PAR(1'b1)) u_odd (
    .eck(eck), .er(er), .eena(eena), .ed(ed), .eld(eld), .ecl(ecl),
    .sq(sq_o), .sbusy(sbusy_o), .sack(sack_o), .sdone(sdone_o)
  );

  initial eck = 1'b0;
  always #5 eck = ~eck;

  task automatic tick;
    @(posedge eck);
    #1;
  endtask

  task automatic test_reset;
    er = 1'b0; eena = 1'b1; ed = '0; eld = 1'b0; ecl = 1'b0;
    tick(); tick();
    checks++;
    if ({sq, sbusy, sack, sdone} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_hold: got sq/busy/ack/done=%b expected 1000", {sq, sbusy, sack, sdone});
    end
    er = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sq, sbusy, sack, sdone} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %b expected 1000", i, {sq, sbusy, sack, sdone});
      end
    end
  endtask

  task automatic test_frame_101;
    logic [5:0] exp;
    exp = 6'b101010;
    ed = 3'b101; eld = 1'b1;
    tick();
    eld = 1'b0;
    checks++;
    if ({sack, sq, sbusy} !== 3'b110) begin
      errors++;
      $display("FAIL f101_ack: got sack/sq/busy=%b expected 110", {sack, sq, sbusy});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({sq, sbusy, sack, sdone} !== {exp[i], 1'b1, 1'b0, (i == 5)}) begin
        errors++;
        $display("FAIL f101_bit[%0d]: got sq/busy/ack/done=%b expected %b", i,
                 {sq, sbusy, sack, sdone}, {exp[i], 1'b1, 1'b0, (i == 5)});
      end
    end
    tick();
    checks++;
    if ({sq, sbusy, sdone} !== 3'b100) begin
      errors++;
      $display("FAIL f101_end: got sq/busy/done=%b expected 100", {sq, sbusy, sdone});
    end
  endtask

  task automatic test_parity;
    logic [5:0] exp_e, exp_o;
    exp_e = 6'b111000;
    exp_o = 6'b101000;
    ed = 3'b100; eld = 1'b1;
    tick();
    eld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (sq !== exp_e[i]) begin
        errors++;
        $display("FAIL par_even[%0d]: got %b expected %b", i, sq, exp_e[i]);
      end
      checks++;
      if (sq_o !== exp_o[i]) begin
        errors++;
        $display("FAIL par_odd[%0d]: got %b expected %b", i, sq_o, exp_o[i]);
      end
    end
    tick();
  endtask

  task automatic test_freeze;
    logic [8:0] exp;
    exp = 9'b101111100;
    ed = 3'b110; eld = 1'b1;
    tick();
    eld = 1'b0;
    for (int i = 0; i < 9; i++) begin
      eena = !(i >= 3 && i <= 5);
      tick();
      checks++;
      if ({sq, sbusy, sdone} !== {exp[i], 1'b1, (i == 8)}) begin
        errors++;
        $display("FAIL freeze[%0d]: got sq/busy/done=%b expected %b", i,
                 {sq, sbusy, sdone}, {exp[i], 1'b1, (i == 8)});
      end
    end
    eena = 1'b0;
    tick();
    checks++;
    if ({sdone, sbusy} !== 2'b11) begin
      errors++;
      $display("FAIL freeze_done_hold: got done/busy=%b expected 11", {sdone, sbusy});
    end
    eena = 1'b1;
    tick();
    checks++;
    if ({sdone, sbusy, sq} !== 3'b001) begin
      errors++;
      $display("FAIL freeze_done_clear: got done/busy/sq=%b expected 001", {sdone, sbusy, sq});
    end
  endtask

  task automatic test_cancel;
    logic [2:0] exp;
    exp = 3'b010;
    ed = 3'b101; eld = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sq, sack} !== {exp[i], 1'b0}) begin
        errors++;
        $display("FAIL cancel_pre[%0d]: got sq/ack=%b expected %b", i, {sq, sack}, {exp[i], 1'b0});
      end
    end
    ecl = 1'b1;
    tick();
    checks++;
    if ({sq, sbusy, sack, sdone} !== 4'b1000) begin
      errors++;
      $display("FAIL cancel_abort: got sq/busy/ack/done=%b expected 1000", {sq, sbusy, sack, sdone});
    end
    tick();
    checks++;
    if (sack !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle_load: got sack=%b expected 0", sack);
    end
    ecl = 1'b0; eld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sq, sbusy, sack, sdone} !== 4'b1000) begin
        errors++;
        $display("FAIL cancel_after[%0d]: got %b expected 1000", i, {sq, sbusy, sack, sdone});
      end
    end
  endtask

  task automatic test_async_reset;
    logic [5:0] exp;
    ed = 3'b101; eld = 1'b1;
    tick();
    eld = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({sq, sbusy} !== 2'b01) begin
      errors++;
      $display("FAIL areset_par: got sq/busy=%b expected 01", {sq, sbusy});
    end
    #2 er = 1'b0;
    #1;
    checks++;
    if ({sq, sbusy, sack, sdone} !== 4'b1000) begin
      errors++;
      $display("FAIL areset_now: got sq/busy/ack/done=%b expected 1000", {sq, sbusy, sack, sdone});
    end
    tick();
    er = 1'b1;
    tick();
    exp = 6'b100110;
    ed = 3'b011; eld = 1'b1;
    tick();
    eld = 1'b0;
    checks++;
    if (sack !== 1'b1) begin
      errors++;
      $display("FAIL areset_reload_ack: got sack=%b expected 1", sack);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({sq, sdone} !== {exp[i], (i == 5)}) begin
        errors++;
        $display("FAIL areset_frame[%0d]: got sq/done=%b expected %b", i, {sq, sdone}, {exp[i], (i == 5)});
      end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp;
    exp = 6'b110010;
    ed = 3'b001; eld = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({sq, sack} !== {exp[i], 1'b0}) begin
        errors++;
        $display("FAIL b2b_bit[%0d]: got sq/ack=%b expected %b", i, {sq, sack}, {exp[i], 1'b0});
      end
    end
    tick();
    checks++;
    if ({sack, sq, sbusy, sdone} !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_gap: got ack/sq/busy/done=%b expected 1100", {sack, sq, sbusy, sdone});
    end
    eld = 1'b0;
    tick();
    checks++;
    if ({sq, sbusy, sack} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_restart: got sq/busy/ack=%b expected 010", {sq, sbusy, sack});
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    test_reset();
    test_frame_101();
    test_parity();
    test_freeze();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
